// File: rtl/sdio_fbr_pkg.sv
// Shared constants for the SDIO FBR bank: register offsets, FSM states and CSA pointer width.
package sdio_fbr_pkg;

    localparam logic [7:0] OFF_FUNC_IF   = 8'h00;
    localparam logic [7:0] OFF_PWR_SEL   = 8'h02;
    localparam logic [7:0] OFF_CIS_0     = 8'h09;
    localparam logic [7:0] OFF_CIS_1     = 8'h0A;
    localparam logic [7:0] OFF_CIS_2     = 8'h0B;
    localparam logic [7:0] OFF_CSA_PTR_0 = 8'h0C;
    localparam logic [7:0] OFF_CSA_PTR_1 = 8'h0D;
    localparam logic [7:0] OFF_CSA_PTR_2 = 8'h0E;
    localparam logic [7:0] OFF_CSA_DATA  = 8'h0F;
    localparam logic [7:0] OFF_BLK_LO    = 8'h10;
    localparam logic [7:0] OFF_BLK_HI    = 8'h11;
    localparam logic [7:0] OFF_LAST      = 8'h11;

    localparam int unsigned CSA_PTR_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REG_RESP = 2'd1,
        ST_CSA_WAIT = 2'd2
    } fbr_state_e;

endpackage

// File: rtl/sdio_fbr_func_regs.sv
// Per-function FBR state: CSA enable, power select, clamped block size and CSA pointer.
module sdio_fbr_func_regs
    import sdio_fbr_pkg::*;
#(
    parameter logic        CSA_SUP            = 1'b0,
    parameter logic        SPS                = 1'b0,
    parameter int unsigned DEFAULT_BLOCK_SIZE = 256,
    parameter int unsigned MAX_BLOCK_SIZE     = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [7:0]           i_offset,
    input  logic [7:0]           i_wdata,
    input  logic                 i_ptr_inc,
    output logic                 o_csa_en,
    output logic [3:0]           o_pwr_mode,
    output logic [15:0]          o_block_size,
    output logic [CSA_PTR_W-1:0] o_csa_ptr
);

    logic                 csa_en_q, csa_en_d;
    logic [3:0]           pwr_mode_q, pwr_mode_d;
    logic [15:0]          blk_q, blk_d, blk_new;
    logic                 blk_wr;
    logic [CSA_PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        csa_en_d   = csa_en_q;
        pwr_mode_d = pwr_mode_q;
        blk_d      = blk_q;
        blk_new    = blk_q;
        blk_wr     = 1'b0;
        ptr_d      = ptr_q;
        if (i_wr_en) begin
            case (i_offset)
                OFF_FUNC_IF:   csa_en_d = i_wdata[7] & CSA_SUP;
                OFF_PWR_SEL:   if (SPS) pwr_mode_d = i_wdata[7:4];
                OFF_CSA_PTR_0: ptr_d[7:0]   = i_wdata;
                OFF_CSA_PTR_1: ptr_d[15:8]  = i_wdata;
                OFF_CSA_PTR_2: ptr_d[23:16] = i_wdata;
                OFF_BLK_LO: begin
                    blk_new = {blk_q[15:8], i_wdata};
                    blk_wr  = 1'b1;
                end
                OFF_BLK_HI: begin
                    blk_new = {i_wdata, blk_q[7:0]};
                    blk_wr  = 1'b1;
                end
                default: ;
            endcase
        end
        // Each byte write forms a complete 16-bit value that is clamped on its own
        if (blk_wr) begin
            blk_d = (blk_new > 16'(MAX_BLOCK_SIZE)) ? 16'(MAX_BLOCK_SIZE) : blk_new;
        end
        if (i_ptr_inc) begin
            ptr_d = ptr_q + CSA_PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csa_en_q   <= 1'b0;
            pwr_mode_q <= '0;
            blk_q      <= 16'(DEFAULT_BLOCK_SIZE);
            ptr_q      <= '0;
        end else begin
            csa_en_q   <= csa_en_d;
            pwr_mode_q <= pwr_mode_d;
            blk_q      <= blk_d;
            ptr_q      <= ptr_d;
        end
    end

    assign o_csa_en     = csa_en_q;
    assign o_pwr_mode   = pwr_mode_q;
    assign o_block_size = blk_q;
    assign o_csa_ptr    = ptr_q;

endmodule

// File: rtl/sdio_fbr_bank.sv
// Multi-function FBR bank: CIA address decode, read mux, access FSM and CSA window with timeout.
module sdio_fbr_bank
    import sdio_fbr_pkg::*;
#(
    parameter int unsigned NUM_FUNCS          = 2,
    parameter logic [27:0] FUNC_TYPE          = 28'h0,
    parameter logic [6:0]  CSA_SUPPORT        = 7'h0,
    parameter logic [6:0]  SUPPORT_PWR_SEL    = 7'h0,
    parameter logic [23:0] CIS_BASE           = 24'h001000,
    parameter logic [23:0] CIS_STRIDE         = 24'h000100,
    parameter int unsigned DEFAULT_BLOCK_SIZE = 256,
    parameter int unsigned MAX_BLOCK_SIZE     = 2048,
    parameter int unsigned CSA_TIMEOUT        = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_activate,
    input  logic                    i_write_flag,
    input  logic [16:0]             i_address,
    input  logic                    i_data_stb,
    input  logic [7:0]              i_data_in,
    output logic [7:0]              o_data_out,
    output logic                    o_data_rdy,
    output logic                    o_busy,
    output logic                    o_err,
    output logic [NUM_FUNCS-1:0]    o_csa_en,
    output logic [4*NUM_FUNCS-1:0]  o_pwr_mode,
    output logic [16*NUM_FUNCS-1:0] o_block_size,
    output logic                    o_csa_stb,
    output logic                    o_csa_we,
    output logic [2:0]              o_csa_func,
    output logic [23:0]             o_csa_addr,
    output logic [7:0]              o_csa_data,
    input  logic                    i_csa_ack,
    input  logic [7:0]              i_csa_data
);

    fbr_state_e state_q, state_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        rdy_q, rdy_d, err_q, err_d;
    logic        csa_stb_q, csa_stb_d, csa_we_q, csa_we_d;
    logic [2:0]  csa_func_q, csa_func_d;
    logic [23:0] csa_addr_q, csa_addr_d;
    logic [7:0]  csa_data_q, csa_data_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    logic [NUM_FUNCS-1:0] csa_en, wr_en, ptr_inc;
    logic [3:0]           pwr  [NUM_FUNCS];
    logic [15:0]          blk  [NUM_FUNCS];
    logic [23:0]          ptr  [NUM_FUNCS];

    logic [3:0]  func;
    logic [7:0]  offset;
    logic [2:0]  fidx;
    logic        addr_ok, accept, csa_hit;
    logic        sel_csa_en, sel_sup, sel_sps;
    logic [3:0]  sel_type, sel_pwr;
    logic [15:0] sel_blk;
    logic [23:0] sel_ptr, cis_ptr;
    logic [7:0]  rd_data;

    assign func    = i_address[11:8];
    assign offset  = i_address[7:0];
    assign fidx    = func[2:0] - 3'd1;
    assign addr_ok = (i_address[16:12] == 5'd0) && (func != 4'd0) &&
                     (func <= 4'(NUM_FUNCS)) && (offset <= OFF_LAST);
    assign accept  = i_activate & i_data_stb & (state_q == ST_IDLE);
    assign cis_ptr = CIS_BASE + 24'(fidx) * CIS_STRIDE;

    always_comb begin
        sel_csa_en = 1'b0;
        sel_sup    = 1'b0;
        sel_sps    = 1'b0;
        sel_type   = '0;
        sel_pwr    = '0;
        sel_blk    = '0;
        sel_ptr    = '0;
        for (int unsigned f = 0; f < NUM_FUNCS; f++) begin
            if (fidx == 3'(f)) begin
                sel_csa_en = csa_en[f];
                sel_sup    = CSA_SUPPORT[f];
                sel_sps    = SUPPORT_PWR_SEL[f];
                sel_type   = FUNC_TYPE[4*f +: 4];
                sel_pwr    = pwr[f];
                sel_blk    = blk[f];
                sel_ptr    = ptr[f];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_FUNC_IF:   rd_data = {sel_csa_en, sel_sup, 2'b00, sel_type};
            OFF_PWR_SEL:   rd_data = {sel_pwr, 3'b000, sel_sps};
            OFF_CIS_0:     rd_data = cis_ptr[7:0];
            OFF_CIS_1:     rd_data = cis_ptr[15:8];
            OFF_CIS_2:     rd_data = cis_ptr[23:16];
            OFF_CSA_PTR_0: rd_data = sel_ptr[7:0];
            OFF_CSA_PTR_1: rd_data = sel_ptr[15:8];
            OFF_CSA_PTR_2: rd_data = sel_ptr[23:16];
            OFF_BLK_LO:    rd_data = sel_blk[7:0];
            OFF_BLK_HI:    rd_data = sel_blk[15:8];
            default:       rd_data = '0;
        endcase
        if (!addr_ok) begin
            rd_data = '0;
        end
    end

    // A data-window access with CSA disabled falls through to the register path as an invalid access
    assign csa_hit = addr_ok && (offset == OFF_CSA_DATA) && sel_csa_en;

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        rdy_d      = 1'b0;
        err_d      = 1'b0;
        csa_stb_d  = csa_stb_q;
        csa_we_d   = csa_we_q;
        csa_func_d = csa_func_q;
        csa_addr_d = csa_addr_q;
        csa_data_d = csa_data_q;
        tmo_cnt_d  = tmo_cnt_q;
        wr_en      = '0;
        ptr_inc    = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (csa_hit) begin
                        state_d    = ST_CSA_WAIT;
                        csa_stb_d  = 1'b1;
                        csa_we_d   = i_write_flag;
                        csa_func_d = func[2:0];
                        csa_addr_d = sel_ptr;
                        csa_data_d = i_data_in;
                        tmo_cnt_d  = '0;
                    end else begin
                        state_d    = ST_REG_RESP;
                        rdy_d      = 1'b1;
                        data_out_d = rd_data;
                        for (int unsigned f = 0; f < NUM_FUNCS; f++) begin
                            wr_en[f] = i_write_flag && addr_ok &&
                                       (offset != OFF_CSA_DATA) && (fidx == 3'(f));
                        end
                    end
                end
            end
            ST_REG_RESP: state_d = ST_IDLE;
            ST_CSA_WAIT: begin
                if (i_csa_ack) begin
                    state_d    = ST_IDLE;
                    rdy_d      = 1'b1;
                    csa_stb_d  = 1'b0;
                    data_out_d = csa_we_q ? 8'h00 : i_csa_data;
                    for (int unsigned f = 0; f < NUM_FUNCS; f++) begin
                        ptr_inc[f] = (csa_func_q == 3'(f + 1));
                    end
                end else if (tmo_cnt_q == 16'(CSA_TIMEOUT - 1)) begin
                    state_d    = ST_IDLE;
                    rdy_d      = 1'b1;
                    err_d      = 1'b1;
                    csa_stb_d  = 1'b0;
                    data_out_d = 8'h00;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_out_q <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            csa_stb_q  <= 1'b0;
            csa_we_q   <= 1'b0;
            csa_func_q <= '0;
            csa_addr_q <= '0;
            csa_data_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            csa_stb_q  <= csa_stb_d;
            csa_we_q   <= csa_we_d;
            csa_func_q <= csa_func_d;
            csa_addr_q <= csa_addr_d;
            csa_data_q <= csa_data_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_FUNCS; g++) begin : g_func
        sdio_fbr_func_regs #(
            .CSA_SUP            (CSA_SUPPORT[g]),
            .SPS                (SUPPORT_PWR_SEL[g]),
            .DEFAULT_BLOCK_SIZE (DEFAULT_BLOCK_SIZE),
            .MAX_BLOCK_SIZE     (MAX_BLOCK_SIZE)
        ) u_regs (
            .clk          (clk),
            .rst          (rst),
            .i_wr_en      (wr_en[g]),
            .i_offset     (offset),
            .i_wdata      (i_data_in),
            .i_ptr_inc    (ptr_inc[g]),
            .o_csa_en     (csa_en[g]),
            .o_pwr_mode   (pwr[g]),
            .o_block_size (blk[g]),
            .o_csa_ptr    (ptr[g])
        );
        assign o_pwr_mode[4*g +: 4]    = pwr[g];
        assign o_block_size[16*g +: 16] = blk[g];
    end

    assign o_csa_en   = csa_en;
    assign o_data_out = data_out_q;
    assign o_data_rdy = rdy_q;
    assign o_err      = err_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_csa_stb  = csa_stb_q;
    assign o_csa_we   = csa_we_q;
    assign o_csa_func = csa_func_q;
    assign o_csa_addr = csa_addr_q;
    assign o_csa_data = csa_data_q;

endmodule

// File: tb/tb_sdio_fbr_bank.sv
// Directed bench for sdio_fbr_bank: register map, block-size clamp, CSA window, timeout and reset.
module tb_sdio_fbr_bank;

    localparam int unsigned NF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_activate, i_write_flag, i_data_stb, i_csa_ack;
    logic [16:0]   i_address;
    logic [7:0]    i_data_in, i_csa_data;
    logic [7:0]    o_data_out, o_csa_data;
    logic          o_data_rdy, o_busy, o_err, o_csa_stb, o_csa_we;
    logic [NF-1:0] o_csa_en;
    logic [4*NF-1:0]  o_pwr_mode;
    logic [16*NF-1:0] o_block_size;
    logic [2:0]    o_csa_func;
    logic [23:0]   o_csa_addr;

    int n_checks = 0;
    int n_errors = 0;

    logic        seen_stb, seen_we, seen_err;
    logic [23:0] seen_addr;
    logic [7:0]  seen_wdata;
    logic [2:0]  seen_func;

    always #5 clk = ~clk;

    sdio_fbr_bank #(
        .NUM_FUNCS          (NF),
        .FUNC_TYPE          (28'h0000021),
        .CSA_SUPPORT        (7'h01),
        .SUPPORT_PWR_SEL    (7'h01),
        .CIS_BASE           (24'h001000),
        .CIS_STRIDE         (24'h000100),
        .DEFAULT_BLOCK_SIZE (256),
        .MAX_BLOCK_SIZE     (512),
        .CSA_TIMEOUT        (8)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_activate   (i_activate),
        .i_write_flag (i_write_flag),
        .i_address    (i_address),
        .i_data_stb   (i_data_stb),
        .i_data_in    (i_data_in),
        .o_data_out   (o_data_out),
        .o_data_rdy   (o_data_rdy),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_csa_en     (o_csa_en),
        .o_pwr_mode   (o_pwr_mode),
        .o_block_size (o_block_size),
        .o_csa_stb    (o_csa_stb),
        .o_csa_we     (o_csa_we),
        .o_csa_func   (o_csa_func),
        .o_csa_addr   (o_csa_addr),
        .o_csa_data   (o_csa_data),
        .i_csa_ack    (i_csa_ack),
        .i_csa_data   (i_csa_data)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One strobe, then watch up to 40 cycles for o_data_rdy; ack raised in cycle T+ack_at (0 = never)
    task automatic do_access(input logic [3:0] func, input logic [7:0] off, input logic we,
                             input logic [7:0] wdata, input int ack_at, input logic [7:0] ack_data,
                             output logic [7:0] rdata, output int lat);
        @(posedge clk); #1;
        i_activate   = 1'b1;
        i_data_stb   = 1'b1;
        i_write_flag = we;
        i_address    = {5'd0, func, off};
        i_data_in    = wdata;
        lat = 0; rdata = 8'h00; seen_stb = 1'b0; seen_err = 1'b0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk); #1;
            i_activate = 1'b0;
            i_data_stb = 1'b0;
            i_csa_ack  = 1'b0;
            if (o_data_rdy) begin
                lat      = c;
                rdata    = o_data_out;
                seen_err = o_err;
            end else if (o_csa_stb) begin
                seen_stb   = 1'b1;
                seen_addr  = o_csa_addr;
                seen_we    = o_csa_we;
                seen_wdata = o_csa_data;
                seen_func  = o_csa_func;
                if (c == ack_at) begin
                    i_csa_ack  = 1'b1;
                    i_csa_data = ack_data;
                end
            end
        end
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] func, input logic [7:0] off,
                          input logic [7:0] exp);
        logic [7:0] d;
        int lat;
        do_access(func, off, 1'b0, 8'h00, 0, 8'h00, d, lat);
        check_val({tag, "_lat"}, lat, 1);
        check_val(tag, d, exp);
        check_val({tag, "_nostb"}, seen_stb, 0);
    endtask

    task automatic wr(input string tag, input logic [3:0] func, input logic [7:0] off,
                      input logic [7:0] data);
        logic [7:0] d;
        int lat;
        do_access(func, off, 1'b1, data, 0, 8'h00, d, lat);
        check_val({tag, "_lat"}, lat, 1);
    endtask

    task automatic csa_chk(input string tag, input logic we, input logic [7:0] wdata,
                           input int ack_at, input logic [7:0] ack_data, input logic [23:0] exp_addr,
                           input int exp_lat, input logic [7:0] exp_rd, input logic exp_err);
        logic [7:0] d;
        int lat;
        do_access(4'd1, 8'h0F, we, wdata, ack_at, ack_data, d, lat);
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_stb"}, seen_stb, 1);
        check_val({tag, "_addr"}, seen_addr, exp_addr);
        check_val({tag, "_we"}, seen_we, we);
        check_val({tag, "_func"}, seen_func, 1);
        check_val({tag, "_err"}, seen_err, exp_err);
        if (!we) check_val({tag, "_data"}, d, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_activate = 1'b0; i_write_flag = 1'b0; i_address = '0;
        i_data_stb = 1'b0; i_data_in = '0; i_csa_ack = 1'b0; i_csa_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_val("rst_rdy", o_data_rdy, 0);
        check_val("rst_stb", o_csa_stb, 0);
        check_val("rst_busy", o_busy, 0);
        check_val("rst_err", o_err, 0);
        check_val("rst_dout", o_data_out, 0);
        check_val("rst_blk", o_block_size, 32'h0100_0100);
        check_val("rst_csa_en", o_csa_en, 0);
        check_val("rst_pwr", o_pwr_mode, 0);

        rd_chk("f2_blk_lo", 4'd2, 8'h10, 8'h00);
        rd_chk("f2_blk_hi", 4'd2, 8'h11, 8'h01);
        rd_chk("f1_cis0", 4'd1, 8'h09, 8'h00);
        rd_chk("f1_cis1", 4'd1, 8'h0A, 8'h10);
        rd_chk("f1_cis2", 4'd1, 8'h0B, 8'h00);
        rd_chk("f2_cis0", 4'd2, 8'h09, 8'h00);
        rd_chk("f2_cis1", 4'd2, 8'h0A, 8'h11);
        rd_chk("f2_cis2", 4'd2, 8'h0B, 8'h00);
        rd_chk("f1_if", 4'd1, 8'h00, 8'h41);
        rd_chk("f2_if", 4'd2, 8'h00, 8'h02);

        wr("f1_blk_lo_wr", 4'd1, 8'h10, 8'h34);
        check_val("f1_blk_0134", o_block_size[15:0], 16'h0134);
        wr("f1_blk_hi_wr", 4'd1, 8'h11, 8'h12);
        check_val("f1_blk_clamp", o_block_size[15:0], 16'h0200);
        check_val("f2_blk_keep", o_block_size[31:16], 16'h0100);

        wr("f1_pwr_wr", 4'd1, 8'h02, 8'hA0);
        rd_chk("f1_pwr_rd", 4'd1, 8'h02, 8'hA1);
        check_val("f1_pwr_out", o_pwr_mode[3:0], 4'hA);
        wr("f2_pwr_wr", 4'd2, 8'h02, 8'h50);
        rd_chk("f2_pwr_rd", 4'd2, 8'h02, 8'h00);
        check_val("f2_pwr_out", o_pwr_mode[7:4], 4'h0);

        rd_chk("bad_func5", 4'd5, 8'h00, 8'h00);
        rd_chk("bad_off15", 4'd1, 8'h15, 8'h00);
        rd_chk("csa_off_rd", 4'd1, 8'h0F, 8'h00);
        wr("f2_csa_en_wr", 4'd2, 8'h00, 8'h80);
        rd_chk("f2_csa_unsup", 4'd2, 8'h00, 8'h02);

        wr("f1_csa_en_wr", 4'd1, 8'h00, 8'h80);
        rd_chk("f1_csa_en_rd", 4'd1, 8'h00, 8'hC1);
        check_val("csa_en_out", o_csa_en, 2'b01);
        wr("ptr0_wr", 4'd1, 8'h0C, 8'hFE);
        wr("ptr1_wr", 4'd1, 8'h0D, 8'hFF);
        wr("ptr2_wr", 4'd1, 8'h0E, 8'hFF);
        rd_chk("ptr2_rd", 4'd1, 8'h0E, 8'hFF);

        csa_chk("csa_rd0", 1'b0, 8'h00, 3, 8'h5A, 24'hFFFFFE, 4, 8'h5A, 1'b0);
        csa_chk("csa_rd1", 1'b0, 8'h00, 3, 8'hA5, 24'hFFFFFF, 4, 8'hA5, 1'b0);
        csa_chk("csa_rd2", 1'b0, 8'h00, 3, 8'h3C, 24'h000000, 4, 8'h3C, 1'b0);
        rd_chk("ptr_wrap_lo", 4'd1, 8'h0C, 8'h01);
        rd_chk("ptr_wrap_hi", 4'd1, 8'h0E, 8'h00);

        csa_chk("csa_wr", 1'b1, 8'h77, 1, 8'h00, 24'h000001, 2, 8'h00, 1'b0);
        check_val("csa_wr_data", seen_wdata, 8'h77);

        csa_chk("csa_tmo", 1'b0, 8'h00, 0, 8'h00, 24'h000002, 9, 8'h00, 1'b1);
        check_val("tmo_busy", o_busy, 0);
        rd_chk("tmo_ptr", 4'd1, 8'h0C, 8'h02);

        // Strobe while busy must be dropped
        @(posedge clk); #1;
        i_activate = 1'b1; i_data_stb = 1'b1; i_write_flag = 1'b0; i_address = {5'd0, 4'd1, 8'h0F};
        @(posedge clk); #1;
        i_write_flag = 1'b1; i_address = {5'd0, 4'd1, 8'h10}; i_data_in = 8'h05;
        check_val("busy_set", o_busy, 1);
        check_val("busy_stb", o_csa_stb, 1);
        check_val("busy_addr", o_csa_addr, 24'h000002);
        @(posedge clk); #1;
        i_activate = 1'b0; i_data_stb = 1'b0; i_csa_ack = 1'b1; i_csa_data = 8'h11;
        check_val("busy_no_rdy", o_data_rdy, 0);
        @(posedge clk); #1;
        i_csa_ack = 1'b0;
        check_val("busy_rdy", o_data_rdy, 1);
        check_val("busy_data", o_data_out, 8'h11);
        check_val("busy_blk_keep", o_block_size[15:0], 16'h0200);
        @(posedge clk); #1;
        check_val("busy_no_extra_rdy", o_data_rdy, 0);

        // Reset while waiting on CSA
        @(posedge clk); #1;
        i_activate = 1'b1; i_data_stb = 1'b1; i_write_flag = 1'b0; i_address = {5'd0, 4'd1, 8'h0F};
        @(posedge clk); #1;
        i_activate = 1'b0; i_data_stb = 1'b0;
        check_val("rstw_stb_up", o_csa_stb, 1);
        check_val("rstw_addr", o_csa_addr, 24'h000003);
        rst = 1'b1; i_csa_ack = 1'b1; i_csa_data = 8'h99;
        @(posedge clk); #1;
        check_val("rstw_stb_low", o_csa_stb, 0);
        check_val("rstw_no_rdy", o_data_rdy, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        i_csa_ack = 1'b0;
        check_val("rstw_no_rdy2", o_data_rdy, 0);
        check_val("rstw_busy", o_busy, 0);
        check_val("rstw_blk", o_block_size, 32'h0100_0100);
        check_val("rstw_csa_en", o_csa_en, 0);
        check_val("rstw_pwr", o_pwr_mode, 0);
        rd_chk("rstw_ptr", 4'd1, 8'h0C, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
